// File: rtl/spi_xfer_arb.sv
// rtl/spi_xfer_arb.sv - two-requester round-robin arbiter and byte sequencer for the SPI byte engine
// Grants the engine, sequences load/unload around spi_ssn, returns the byte and acks, with watchdog abort.
module spi_xfer_arb #(
  parameter int START_MAX = 3,
  parameter int SHIFT_MAX = 15
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       lock_a,
  input  logic       lock_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       err_a,
  output logic       err_b,
  output logic [1:0] cs_n,
  output logic       busy,
  output logic       spi_load,
  output logic       spi_unload,
  output logic [7:0] spi_datain,
  input  logic [7:0] spi_dataout,
  input  logic       spi_ssn
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_SHIFT, S_UNLOAD, S_DONE, S_ABORT
  } state_t;

  localparam logic [4:0] START_LIM = 5'(START_MAX);
  localparam logic [4:0] SHIFT_LIM = 5'(SHIFT_MAX);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       ptr_q, ptr_d;
  logic       locked_q, locked_d;
  logic [4:0] wdog_q, wdog_d;
  logic [1:0] cs_n_q, cs_n_d;
  logic [7:0] datain_q, datain_d;
  logic [7:0] rdata_a_q, rdata_a_d;
  logic [7:0] rdata_b_q, rdata_b_d;

  logic       grant;
  logic       winner;
  logic [4:0] wdog_inc;

  // Saturating so a very long stall can never wrap back under the limit.
  assign wdog_inc = (wdog_q == 5'd31) ? wdog_q : wdog_q + 5'd1;

  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    if (locked_q) begin
      grant  = owner_q ? req_b : req_a;
      winner = owner_q;
    end else if (req_a && req_b) begin
      grant  = 1'b1;
      winner = ptr_q;
    end else if (req_a || req_b) begin
      grant  = 1'b1;
      winner = req_b;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    locked_d  = locked_q;
    wdog_d    = wdog_q;
    cs_n_d    = cs_n_q;
    datain_d  = datain_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          datain_d = winner ? wdata_b : wdata_a;
          owner_d  = winner;
          cs_n_d   = winner ? 2'b01 : 2'b10;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        wdog_d  = 5'd0;
        state_d = S_START;
      end
      S_START: begin
        if (!spi_ssn) begin
          wdog_d  = 5'd0;
          state_d = S_SHIFT;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc >= START_LIM) state_d = S_ABORT;
        end
      end
      S_SHIFT: begin
        if (spi_ssn) begin
          state_d = S_UNLOAD;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc >= SHIFT_LIM) state_d = S_ABORT;
        end
      end
      S_UNLOAD: begin
        if (owner_q) rdata_b_d = spi_dataout;
        else         rdata_a_d = spi_dataout;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (owner_q ? lock_b : lock_a) begin
          locked_d = 1'b1;
        end else begin
          locked_d = 1'b0;
          cs_n_d   = 2'b11;
          ptr_d    = ~owner_q;
        end
        state_d = S_IDLE;
      end
      S_ABORT: begin
        locked_d = 1'b0;
        cs_n_d   = 2'b11;
        ptr_d    = ~owner_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      locked_q  <= 1'b0;
      wdog_q    <= 5'd0;
      cs_n_q    <= 2'b11;
      datain_q  <= 8'h00;
      rdata_a_q <= 8'h00;
      rdata_b_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      locked_q  <= locked_d;
      wdog_q    <= wdog_d;
      cs_n_q    <= cs_n_d;
      datain_q  <= datain_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Strobes decode straight from state so an async reset clears them immediately.
  assign busy       = (state_q != S_IDLE);
  assign spi_load   = (state_q == S_LOAD);
  assign spi_unload = (state_q == S_UNLOAD);
  assign ack_a      = (state_q == S_DONE)  && !owner_q;
  assign ack_b      = (state_q == S_DONE)  &&  owner_q;
  assign err_a      = (state_q == S_ABORT) && !owner_q;
  assign err_b      = (state_q == S_ABORT) &&  owner_q;
  assign cs_n       = cs_n_q;
  assign spi_datain = datain_q;
  assign rdata_a    = rdata_a_q;
  assign rdata_b    = rdata_b_q;

endmodule
